committed_store_buffer: RTL and testbench
=========================================

// Module: committed_store_buffer
// PURPOSE
//  Post-commit store FIFO directly downstream of the commit stage. Accepts up to
//  COMMIT_WIDTH retired stores per cycle (address/data/byte-enables from the store
//  queue, pushed on store_commit) and drains them in program order, one per cycle,
//  to the data memory port over a valid/ready handshake. Entries are architectural:
//  never flushed by pipeline recovery. Reports free slots so commit can stall.
// PARAMETERS
//  COMMIT_WIDTH  4   max stores pushed per cycle (lane 0 = oldest)
//  DEPTH         16  entries; power of two, >= COMMIT_WIDTH
//  CNT_W         $clog2(DEPTH)+1  occupancy/free-count width (derived, localparam)
// PORTS
//  clk            in   1               clock
//  rst            in   1               synchronous, active-high reset
//  in_valid       in   COMMIT_WIDTH    per-lane committed-store push
//  in_addr        in   32 x CW         word-aligned byte address per lane
//  in_data        in   32 x CW         store data per lane
//  in_be          in   4 x CW          byte enables per lane
//  free_slots     out  CNT_W           DEPTH - occupancy (registered)
//  empty          out  1               occupancy == 0 (for SYNC/fence drain)
//  overflow       out  1               sticky: push exceeded free_slots
//  mem_req_valid  out  1               head entry presented to memory
//  mem_req_addr   out  32              head address
//  mem_req_data   out  32              head data
//  mem_req_be     out  4               head byte enables
//  mem_req_ready  in   1               memory accepts head this cycle
//  ld_addr        in   32              forwarding probe address (CSB_FWD_EN only)
//  fwd_mask       out  4               bytes supplied by buffer (CSB_FWD_EN only)
//  fwd_data       out  32              forwarded bytes (CSB_FWD_EN only)
// BEHAVIOUR
//  - Reset: head=tail=0, occupancy=0, free_slots=DEPTH, empty=1, overflow=0,
//    mem_req_valid=0, mem_req_addr/data/be=0, fwd_mask=0, fwd_data=0.
//  - Push: valid lanes need not be contiguous; they are compacted in lane order
//    (lower lane = older) into tail, tail+1, ...; pointers wrap mod DEPTH.
//  - Push accepted only if popcount(in_valid) <= free_slots sampled that cycle;
//    otherwise the whole group is dropped, no state change, overflow set (sticky
//    until rst). Commit must guard with free_slots; overflow is a bug indicator.
//  - Pop: mem_req_valid = !empty, driven combinationally from head entry regs.
//    Fire = mem_req_valid & mem_req_ready -> head++ at clock edge. Head fields stay
//    stable while valid & !ready. One pop per cycle max.
//  - Latency: store pushed at edge N is visible as head (if buffer empty) at N+1;
//    no bypass from in_* to mem_req_*.
//  - Simultaneous push+pop: occupancy += pushes - fire; acceptance check uses
//    pre-pop free_slots (a pop does not make room in the same cycle).
//  - Full (free_slots=0): any push -> overflow. Empty: mem_req_valid=0, ready ignored.
//  - free_slots/empty registered, reflect state after the edge.
//  - Pipeline flush has no input here: buffered stores always drain.
//  - rst mid-drain discards all entries immediately; mem_req_valid low next cycle.
// CONFIGURATION
//  CSB_FWD_EN defined: combinational store-to-load forwarding. For each byte b,
//    fwd_mask[b]=1 if any valid entry has addr[31:2]==ld_addr[31:2] and be[b];
//    fwd_data byte b taken from the youngest such entry (nearest tail). Head entry
//    mid-handshake still participates until popped.
//  CSB_FWD_EN undefined: forwarding logic absent; ld_addr ignored; fwd_mask and
//    fwd_data tied 0 (loads must wait on empty before reading overlapping memory).
// TESTING
//  1 Reset: after rst, free_slots=16, empty=1, mem_req_valid=0, overflow=0.
//  2 in_valid=4'b1010 lanes1/3 addr 0x100/0x104, ready=1 -> mem writes 0x100 then
//    0x104 on consecutive cycles; free_slots 14 -> 15 -> 16.
//  3 Backpressure: ready=0 for 5 cycles with head 0x200/0xDEADBEEF -> addr/data/be
//    held stable all 5 cycles; fires once on first ready=1.
//  4 Fill 16 entries, ready=0, then push 1 -> overflow=1, free_slots stays 0,
//    drain yields exactly the original 16 in order; overflow stays 1.
//  5 Wrap: sustained push 3/cycle + pop 1/cycle across 40 stores with stalls -> mem
//    sequence equals push order, occupancy never exceeds 16.
//  6 CSB_FWD_EN: store 0x300 be=0011 data 0x11112222, later 0x300 be=0110 data
//    0x33334444; ld_addr=0x300 -> fwd_mask=0111, fwd_data[23:0]=0x334422.

Source files
------------

// File: rtl/committed_store_buffer_if.sv
// -----------------------------------------------------------------------------
// committed_store_buffer_if
// Memory-request bus between the committed store buffer and the data memory
// port. The buffer presents its head entry on this bus, and memory accepts it
// with a valid/ready handshake.
//   mem_req_valid  head entry present
//   mem_req_addr   head word-aligned byte address
//   mem_req_data   head store data
//   mem_req_be     head byte enables
//   mem_req_ready  memory accepts the head this cycle
// Modports: master (buffer side), slave (memory side).
// -----------------------------------------------------------------------------
interface committed_store_buffer_if;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_be;
  logic        mem_req_ready;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_data, mem_req_be,
    input  mem_req_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_data, mem_req_be,
    output mem_req_ready
  );
endinterface

// File: rtl/committed_store_buffer.sv
// -----------------------------------------------------------------------------
// committed_store_buffer
// Post-commit store FIFO. Accepts up to COMMIT_WIDTH retired stores per cycle.
// Valid lanes are compacted in lane order, with lane 0 the oldest. Stores drain
// in program order, one per cycle, over the mem bus. Entries are never flushed;
// only rst discards them.
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   in_valid/addr/data/be per-lane committed-store push
//   free_slots           DEPTH - occupancy (registered)
//   empty                occupancy == 0 (registered)
//   overflow             sticky: a push group exceeded free_slots and was dropped
//   mem                  head-entry request bus (master modport)
//   ld_addr              forwarding probe address
//   fwd_mask, fwd_data   forwarded bytes (zero unless forwarding is built in)
// Build option: define CSB_FWD_EN to include store-to-load forwarding.
// -----------------------------------------------------------------------------
module committed_store_buffer #(
  parameter  int COMMIT_WIDTH = 4,
  parameter  int DEPTH        = 16,
  localparam int CNT_W        = $clog2(DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [COMMIT_WIDTH-1:0]      in_valid,
  input  logic [COMMIT_WIDTH-1:0][31:0] in_addr,
  input  logic [COMMIT_WIDTH-1:0][31:0] in_data,
  input  logic [COMMIT_WIDTH-1:0][3:0]  in_be,
  output logic [CNT_W-1:0]             free_slots,
  output logic                         empty,
  output logic                         overflow,
  committed_store_buffer_if.master     mem,
  input  logic [31:0]                  ld_addr,
  output logic [3:0]                   fwd_mask,
  output logic [31:0]                  fwd_data
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, free_q, free_d;
  logic             empty_q, empty_d, overflow_q, overflow_d;

  logic [31:0] addr_q [DEPTH];
  logic [31:0] addr_d [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [31:0] data_d [DEPTH];
  logic [3:0]  be_q   [DEPTH];
  logic [3:0]  be_d   [DEPTH];

  // Per-lane compaction offset = number of valid lanes below this lane.
  logic [PTR_W-1:0] lane_off [COMMIT_WIDTH];
  logic [PTR_W-1:0] lane_idx [COMMIT_WIDTH];
  logic [PTR_W-1:0] off_acc;
  logic [CNT_W-1:0] push_cnt;
  logic             accept;
  logic             fire;

  always_comb begin
    off_acc  = '0;
    push_cnt = '0;
    for (int l = 0; l < COMMIT_WIDTH; l++) begin
      lane_off[l] = off_acc;
      off_acc     = off_acc + PTR_W'(in_valid[l]);
      push_cnt    = push_cnt + CNT_W'(in_valid[l]);
    end
  end

  for (genvar gi = 0; gi < COMMIT_WIDTH; gi++) begin : g_lane_idx
    assign lane_idx[gi] = tail_q + lane_off[gi];
  end

  // The acceptance check uses the pre-pop count, so a same-cycle pop never
  // makes room for a push.
  assign accept = (push_cnt <= free_q);
  assign fire   = !empty_q && mem.mem_req_ready;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    overflow_d = overflow_q;
    addr_d     = addr_q;
    data_d     = data_q;
    be_d       = be_q;
    if (accept) begin
      for (int l = 0; l < COMMIT_WIDTH; l++) begin
        if (in_valid[l]) begin
          addr_d[lane_idx[l]] = in_addr[l];
          data_d[lane_idx[l]] = in_data[l];
          be_d[lane_idx[l]]   = in_be[l];
        end
      end
      tail_d = tail_q + PTR_W'(push_cnt);
    end else begin
      overflow_d = 1'b1;
    end
    if (fire) begin
      head_d = head_q + PTR_W'(1);
    end
    cnt_d   = cnt_q + (accept ? push_cnt : '0) - CNT_W'(fire);
    free_d  = CNT_W'(DEPTH) - cnt_d;
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
      free_q     <= CNT_W'(DEPTH);
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
      free_q     <= free_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage needs no reset. Occupancy decides which entries are live.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
    be_q   <= be_d;
  end

  assign free_slots = free_q;
  assign empty      = empty_q;
  assign overflow   = overflow_q;

  // Head fields are forced to zero while empty, so the bus reads clean after reset.
  assign mem.mem_req_valid = !empty_q;
  assign mem.mem_req_addr  = empty_q ? '0 : addr_q[head_q];
  assign mem.mem_req_data  = empty_q ? '0 : data_q[head_q];
  assign mem.mem_req_be    = empty_q ? '0 : be_q[head_q];

`ifdef CSB_FWD_EN
  logic [PTR_W-1:0] fwd_idx;
  logic             unused_ld_lo;
  assign unused_ld_lo = ^ld_addr[1:0];

  // Scan from head (oldest) to tail. A later match overwrites an earlier one,
  // so each byte ends up holding the youngest store's value.
  always_comb begin
    fwd_mask = '0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head_q + PTR_W'(k);
      if ((CNT_W'(k) < cnt_q) && (addr_q[fwd_idx][31:2] == ld_addr[31:2])) begin
        for (int b = 0; b < 4; b++) begin
          if (be_q[fwd_idx][b]) begin
            fwd_mask[b]        = 1'b1;
            fwd_data[8*b +: 8] = data_q[fwd_idx][8*b +: 8];
          end
        end
      end
    end
  end
`else
  logic unused_ld;
  assign unused_ld = ^ld_addr;
  assign fwd_mask  = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_committed_store_buffer.sv
module tb_committed_store_buffer;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } st_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       in_valid;
  logic [3:0][31:0] in_addr;
  logic [3:0][31:0] in_data;
  logic [3:0][3:0]  in_be;
  logic [4:0]       free_slots;
  logic             empty;
  logic             overflow;
  logic [31:0]      ld_addr;
  logic [3:0]       fwd_mask;
  logic [31:0]      fwd_data;

  committed_store_buffer_if mem_bus ();

  committed_store_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .in_be      (in_be),
    .free_slots (free_slots),
    .empty      (empty),
    .overflow   (overflow),
    .mem        (mem_bus.master),
    .ld_addr    (ld_addr),
    .fwd_mask   (fwd_mask),
    .fwd_data   (fwd_data)
  );

  always #5 clk = ~clk;

  int  checks   = 0;
  int  failures = 0;
  int  pops     = 0;
  st_t sb[$];

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one push cycle. Accepted stores are queued as expected in lane order.
  task automatic push_cycle(input logic [3:0] v, input logic [3:0][31:0] a,
                            input logic [3:0][31:0] d, input logic [3:0][3:0] be,
                            input bit accept);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    in_be    = be;
    if (accept) begin
      for (int l = 0; l < 4; l++) begin
        if (v[l]) sb.push_back({a[l], d[l], be[l]});
      end
    end
    tick();
    in_valid = '0;
  endtask

  // Memory-side monitor: every handshake must match the oldest expected store.
  always @(negedge clk) begin
    if (!rst && mem_bus.mem_req_valid && mem_bus.mem_req_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_pop", 72'(1), 72'(0));
      end else begin
        st_t e;
        e = sb.pop_front();
        chk("mem_req", 72'({mem_bus.mem_req_addr, mem_bus.mem_req_data, mem_bus.mem_req_be}),
            72'(e));
        pops++;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0][31:0] a, d;
    logic [3:0][3:0]  be;
    int               pushed, cyc, npops;
    logic [3:0]       v;

    rst = 1'b1; in_valid = '0; in_addr = '0; in_data = '0; in_be = '0;
    ld_addr = '0; mem_bus.mem_req_ready = 1'b0;
    a = '0; d = '0; be = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_free", 72'(free_slots), 72'(16));
    chk("rst_empty", 72'(empty), 72'(1));
    chk("rst_valid", 72'(mem_bus.mem_req_valid), 72'(0));
    chk("rst_overflow", 72'(overflow), 72'(0));
    chk("rst_addr", 72'(mem_bus.mem_req_addr), 72'(0));
    chk("rst_fwd_mask", 72'(fwd_mask), 72'(0));

    // Non-contiguous lanes 1 and 3, drained back to back
    mem_bus.mem_req_ready = 1'b1;
    a = '0; d = '0; be = '0;
    a[1] = 32'h100; d[1] = 32'hA1A1A1A1; be[1] = 4'hF;
    a[3] = 32'h104; d[3] = 32'hA3A3A3A3; be[3] = 4'h3;
    push_cycle(4'b1010, a, d, be, 1'b1);
    chk("lanes_free14", 72'(free_slots), 72'(14));
    chk("lanes_head0", 72'(mem_bus.mem_req_addr), 72'(32'h100));
    tick();
    chk("lanes_free15", 72'(free_slots), 72'(15));
    chk("lanes_head1", 72'(mem_bus.mem_req_addr), 72'(32'h104));
    tick();
    chk("lanes_free16", 72'(free_slots), 72'(16));
    chk("lanes_empty", 72'(empty), 72'(1));
    chk("lanes_sb", 72'(sb.size()), 72'(0));

    // Backpressure: the head stays stable while ready is low
    mem_bus.mem_req_ready = 1'b0;
    a = '0; d = '0; be = '0;
    a[0] = 32'h200; d[0] = 32'hDEADBEEF; be[0] = 4'hF;
    push_cycle(4'b0001, a, d, be, 1'b1);
    npops = pops;
    for (int i = 0; i < 5; i++) begin
      chk("bp_head", 72'({mem_bus.mem_req_valid, mem_bus.mem_req_addr,
                          mem_bus.mem_req_data, mem_bus.mem_req_be}),
          72'({1'b1, 32'h200, 32'hDEADBEEF, 4'hF}));
      tick();
    end
    mem_bus.mem_req_ready = 1'b1;
    tick();
    mem_bus.mem_req_ready = 1'b0;
    chk("bp_one_fire", 72'(pops - npops), 72'(1));
    chk("bp_empty", 72'(empty), 72'(1));

    // Fill to 16, overflow, then push again while a pop is in flight
    for (int k = 0; k < 4; k++) begin
      for (int l = 0; l < 4; l++) begin
        a[l] = 32'h1000 + 32'(16 * k + 4 * l);
        d[l] = $urandom;
        be[l] = 4'(l + 1);
      end
      push_cycle(4'b1111, a, d, be, 1'b1);
    end
    chk("full_free0", 72'(free_slots), 72'(0));
    chk("full_no_overflow", 72'(overflow), 72'(0));
    a = '0; d = '0; be = '0;
    a[2] = 32'hBAD0; d[2] = 32'hBADBAD00; be[2] = 4'hF;
    push_cycle(4'b0100, a, d, be, 1'b0);
    chk("ovf_set", 72'(overflow), 72'(1));
    chk("ovf_free0", 72'(free_slots), 72'(0));
    mem_bus.mem_req_ready = 1'b1;
    push_cycle(4'b0100, a, d, be, 1'b0);
    chk("ovf_prepop_free1", 72'(free_slots), 72'(1));
    cyc = 0;
    while (!empty && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("ovf_drained", 72'(empty), 72'(1));
    chk("ovf_sb", 72'(sb.size()), 72'(0));
    chk("ovf_sticky", 72'(overflow), 72'(1));

    // Wrap: guarded multi-lane pushes with random stalls
    pushed = 0;
    cyc = 0;
    while (pushed < 40 && cyc < 400) begin
      mem_bus.mem_req_ready = ($urandom_range(0, 3) != 0);
      v = 4'($urandom_range(0, 15));
      if ($countones(v) > 3) v = v & 4'b1011;
      if ($countones(v) > 16 - sb.size() || pushed + $countones(v) > 40) v = '0;
      for (int l = 0; l < 4; l++) begin
        a[l] = 32'h4000 + 32'(4 * (pushed + $countones(v & ((4'b1 << l) - 4'b1))));
        d[l] = $urandom;
        be[l] = 4'($urandom_range(1, 15));
      end
      pushed += $countones(v);
      push_cycle(v, a, d, be, 1'b1);
      chk("wrap_free", 72'(free_slots), 72'(16 - sb.size()));
      cyc++;
    end
    chk("wrap_pushed", 72'(pushed), 72'(40));
    mem_bus.mem_req_ready = 1'b1;
    cyc = 0;
    while (!empty && cyc < 60) begin
      tick();
      cyc++;
    end
    chk("wrap_drained", 72'(empty), 72'(1));
    chk("wrap_sb", 72'(sb.size()), 72'(0));

    // Reset mid-drain discards everything
    mem_bus.mem_req_ready = 1'b0;
    a = '0; d = '0; be = '0;
    a[0] = 32'h500; a[1] = 32'h504; be[0] = 4'hF; be[1] = 4'hF;
    push_cycle(4'b0011, a, d, be, 1'b1);
    rst = 1'b1;
    tick();
    sb.delete();
    rst = 1'b0;
    chk("rstmid_valid", 72'(mem_bus.mem_req_valid), 72'(0));
    chk("rstmid_free", 72'(free_slots), 72'(16));
    chk("rstmid_overflow", 72'(overflow), 72'(0));

    // Forwarding from two overlapping stores to 0x300
    a = '0; d = '0; be = '0;
    a[0] = 32'h300; d[0] = 32'h11112222; be[0] = 4'b0011;
    push_cycle(4'b0001, a, d, be, 1'b1);
    a[0] = 32'h300; d[0] = 32'h33334444; be[0] = 4'b0110;
    push_cycle(4'b0001, a, d, be, 1'b1);
    ld_addr = 32'h300;
    #1;
`ifdef CSB_FWD_EN
    chk("fwd_mask", 72'(fwd_mask), 72'(4'b0111));
    chk("fwd_data", 72'(fwd_data[23:0]), 72'(24'h334422));
`else
    chk("fwd_mask_off", 72'(fwd_mask), 72'(0));
    chk("fwd_data_off", 72'(fwd_data), 72'(0));
`endif
    ld_addr = 32'h304;
    #1;
    chk("fwd_miss", 72'(fwd_mask), 72'(0));
    mem_bus.mem_req_ready = 1'b1;
    cyc = 0;
    while (!empty && cyc < 10) begin
      tick();
      cyc++;
    end
    chk("fwd_drained", 72'(sb.size()), 72'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
